// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding, FSM states, flag bundle.
// Build option: SEQ_ALU_MUL_EN enables the iterative multiplier (MUL opcode).
package seq_alu_pkg;

  localparam int ALU_OPW = 4;

  // Codes 0xC..0xF are illegal; MUL is illegal too when the multiplier is absent.
  typedef enum logic [ALU_OPW-1:0] {
    OP_ADD  = 4'h0,
    OP_ADDC = 4'h1,
    OP_SUB  = 4'h2,
    OP_SUBC = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_NAND = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_ASR  = 4'hA,
    OP_MUL  = 4'hB
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } alu_state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic ovf;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH cycles after start. The product is presented combinationally in the
// cycle done is high so the caller can register it on that same edge.
module seq_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH);

  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_step;

  // Accumulate the current partial product; load fresh operands on start.
  always_comb begin
    busy_d   = busy_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    done     = busy_q && (cnt_q == CW'(WIDTH-1));
    prod     = acc_step;
    if (start) begin
      busy_d   = 1'b1;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  // Datapath registers, cleared on reset so an aborted multiply leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on both sides. Single-cycle ops
// register their result on the edge after acceptance; MUL (only when
// SEQ_ALU_MUL_EN is defined) runs through the iterative multiplier. A result
// is held until consumed; a new op may be accepted in the consuming cycle.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = ALU_OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic             ovf,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  alu_flags_t       flags_q, flags_d;
  logic             cflag_q, cflag_d;

  alu_op_t          op;
  logic             accept;
  logic             cin;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   sum, dif, shl_x, shr_x, asr_x;
  logic [WIDTH-1:0] c_out;
  alu_flags_t       c_flags;

`ifdef SEQ_ALU_MUL_EN
  logic               is_mul;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   hi_q, hi_d;

  assign is_mul = (op == OP_MUL);

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (alu_in1),
    .b     (alu_in2),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  assign alu_out_hi = hi_q;
`else
  assign alu_out_hi = '0;
`endif

  assign op        = alu_op_t'(opcode);
  assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign alu_out   = out_q;
  assign zero      = flags_q.zero;
  assign carry     = flags_q.carry;
  assign neg       = flags_q.neg;
  assign ovf       = flags_q.ovf;
  assign err       = flags_q.err;

  // Shared arithmetic/shift datapath. Shifts work on a vector one bit wider so
  // the extra bit holds the last bit shifted out (0 when the amount is 0).
  always_comb begin
    cin   = ((op == OP_ADDC) || (op == OP_SUBC)) ? cflag_q : 1'b0;
    sh    = alu_in2[SHW-1:0];
    sum   = {1'b0, alu_in1} + {1'b0, alu_in2} + {{WIDTH{1'b0}}, cin};
    dif   = {1'b0, alu_in1} - {1'b0, alu_in2} - {{WIDTH{1'b0}}, cin};
    shl_x = {1'b0, alu_in1} << sh;
    shr_x = {alu_in1, 1'b0} >> sh;
    asr_x = $signed({alu_in1, 1'b0}) >>> sh;
  end

  // Single-cycle result and flags; anything not handled here reports err.
  always_comb begin
    c_out   = '0;
    c_flags = '0;
    case (op)
      OP_ADD, OP_ADDC: begin
        c_out         = sum[WIDTH-1:0];
        c_flags.carry = sum[WIDTH];
        c_flags.ovf   = (alu_in1[WIDTH-1] == alu_in2[WIDTH-1]) &&
                        (sum[WIDTH-1] != alu_in1[WIDTH-1]);
      end
      OP_SUB, OP_SUBC: begin
        c_out         = dif[WIDTH-1:0];
        c_flags.carry = dif[WIDTH];
        c_flags.ovf   = (alu_in1[WIDTH-1] != alu_in2[WIDTH-1]) &&
                        (dif[WIDTH-1] != alu_in1[WIDTH-1]);
      end
      OP_AND:  c_out = alu_in1 & alu_in2;
      OP_OR:   c_out = alu_in1 | alu_in2;
      OP_XOR:  c_out = alu_in1 ^ alu_in2;
      OP_NAND: c_out = ~(alu_in1 & alu_in2);
      OP_SHL: begin
        c_out         = shl_x[WIDTH-1:0];
        c_flags.carry = shl_x[WIDTH];
      end
      OP_SHR: begin
        c_out         = shr_x[WIDTH:1];
        c_flags.carry = shr_x[0];
      end
      OP_ASR: begin
        c_out         = asr_x[WIDTH:1];
        c_flags.carry = asr_x[0];
      end
      default: c_flags.err = 1'b1;
    endcase
    if (!c_flags.err) begin
      c_flags.zero = (c_out == '0);
      c_flags.neg  = c_out[WIDTH-1];
    end
  end

  // Control FSM: accept, launch or complete an op, and hold the result until consumed.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    flags_d = flags_q;
    cflag_d = cflag_q;
`ifdef SEQ_ALU_MUL_EN
    hi_d      = hi_q;
    mul_start = 1'b0;
`endif
    case (state_q)
`ifdef SEQ_ALU_MUL_EN
      BUSY: begin
        if (mul_done) begin
          out_d         = mul_prod[WIDTH-1:0];
          hi_d          = mul_prod[2*WIDTH-1:WIDTH];
          flags_d       = '0;
          flags_d.zero  = (mul_prod == '0);
          flags_d.carry = |mul_prod[2*WIDTH-1:WIDTH];
          flags_d.neg   = mul_prod[WIDTH-1];
          cflag_d       = |mul_prod[2*WIDTH-1:WIDTH];
          state_d       = HOLD;
        end
      end
`endif
      default: begin
        if (accept) begin
`ifdef SEQ_ALU_MUL_EN
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = BUSY;
          end else begin
            out_d   = c_out;
            hi_d    = '0;
            flags_d = c_flags;
            if (!c_flags.err) cflag_d = c_flags.carry;
            state_d = HOLD;
          end
`else
          out_d   = c_out;
          flags_d = c_flags;
          if (!c_flags.err) cflag_d = c_flags.carry;
          state_d = HOLD;
`endif
        end else if ((state_q == HOLD) && out_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State, result and carry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      flags_q <= '0;
      cflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      flags_q <= flags_d;
      cflag_q <= cflag_d;
    end
  end

`ifdef SEQ_ALU_MUL_EN
  // High half of the product, cleared for every non-MUL result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hi_q <= '0;
    else        hi_q <= hi_d;
  end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed corner cases plus
// randomized ops against an integer reference model. Honours SEQ_ALU_MUL_EN.
module tb_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = '0;
  logic [W-1:0] alu_in1 = '0;
  logic [W-1:0] alu_in2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] alu_out;
  logic [W-1:0] alu_out_hi;
  logic         zero, carry, neg, ovf, err;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state and expectations for the pending result
  int m_cflag = 0;
  int e_out = 0, e_hi = 0, e_flg = 0, e_lat = 1;

  seq_alu #(.WIDTH(W), .OPW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_out    (alu_out),
    .alu_out_hi (alu_out_hi),
    .zero       (zero),
    .carry      (carry),
    .neg        (neg),
    .ovf        (ovf),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic from the operation definitions.
  task automatic model(input int op, input int a, input int b);
    int sa, sb, r, sr, sh, c, v, e, z;
    longint p;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    sh = b % 8;
    r = 0; sr = 0; c = 0; v = 0; e = 0; p = 0;
    e_hi = 0; e_lat = 1;
    case (op)
      0, 1: begin
        r  = a + b + ((op == 1) ? m_cflag : 0);
        sr = sa + sb + ((op == 1) ? m_cflag : 0);
        c  = (r > 255) ? 1 : 0;
        v  = (sr > 127 || sr < -128) ? 1 : 0;
        r  = r & 255;
      end
      2, 3: begin
        r  = a - b - ((op == 3) ? m_cflag : 0);
        sr = sa - sb - ((op == 3) ? m_cflag : 0);
        c  = (r < 0) ? 1 : 0;
        v  = (sr > 127 || sr < -128) ? 1 : 0;
        r  = r & 255;
      end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = (~(a & b)) & 255;
      8: begin
        r = (a << sh) & 255;
        c = (sh != 0) ? ((a >> (8 - sh)) & 1) : 0;
      end
      9: begin
        r = a >> sh;
        c = (sh != 0) ? ((a >> (sh - 1)) & 1) : 0;
      end
      10: begin
        r = (sa >>> sh) & 255;
        c = (sh != 0) ? ((sa >>> (sh - 1)) & 1) : 0;
      end
`ifdef SEQ_ALU_MUL_EN
      11: begin
        p     = longint'(a) * longint'(b);
        r     = int'(p % 256);
        e_hi  = int'(p / 256);
        c     = (e_hi != 0) ? 1 : 0;
        e_lat = W + 1;
      end
`endif
      default: e = 1;
    endcase
    if (e != 0) begin
      e_out = 0;
      e_hi  = 0;
      e_flg = 1;
    end else begin
      if (op == 11) z = (p == 0) ? 1 : 0;
      else          z = (r == 0) ? 1 : 0;
      e_out   = r;
      e_flg   = z * 16 + c * 8 + ((r >> 7) & 1) * 4 + v * 2;
      m_cflag = c;
    end
  endtask

  // Offer one op (already aligned #1 after a rising edge) and let it be accepted.
  task automatic start_op(input int op, input int a, input int b);
    opcode   = op[3:0];
    alu_in1  = a[7:0];
    alu_in2  = b[7:0];
    in_valid = 1'b1;
    chk("in_ready", in_ready, 1);
    model(op, a, b);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_out"}, alu_out, e_out);
    chk({tag, "_hi"}, alu_out_hi, e_hi);
    chk({tag, "_flags"}, {zero, carry, neg, ovf, err}, e_flg);
  endtask

  task automatic wait_res(input string tag);
    int n;
    n = 1;
    while (!out_valid && n < 40) begin
      chk({tag, "_busy_rdy"}, in_ready, 0);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, e_lat);
    check_out(tag);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drained", out_valid, 0);
  endtask

  initial begin
    int seen;
    int op, a, b;

    // reset state, asserted asynchronously from time 0
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_out", alu_out, 0);
    chk("rst_hi", alu_out_hi, 0);
    chk("rst_flags", {zero, carry, neg, ovf, err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", in_ready, 1);
    @(posedge clk); #1;

    // add with carry out, then ADDC consumes it
    start_op(0, 'hFF, 'h01); wait_res("add_ff"); consume();
    start_op(1, 'h00, 'h00); wait_res("addc"); consume();
    // borrow and signed overflow
    start_op(2, 'h05, 'h07); wait_res("sub"); consume();
    start_op(0, 'h7F, 'h01); wait_res("add_ovf"); consume();

    // MUL (legal or illegal depending on build); set cflag first to expose changes
    start_op(0, 'hFF, 'h01); wait_res("pre_mul"); consume();
    start_op(11, 'h0F, 'h11); wait_res("mul"); consume();
    start_op(1, 'h00, 'h00); wait_res("post_mul"); consume();
    start_op(0, 'hFF, 'h01); wait_res("pre_ill"); consume();
    start_op(15, 'hAA, 'h55); wait_res("illegal"); consume();
    start_op(1, 'h00, 'h00); wait_res("post_ill"); consume();

    // back-pressure: result held 3 cycles while another op waits, then no bubble
    start_op(0, 'h12, 'h34); wait_res("bp_a");
    opcode = 4'h6; alu_in1 = 8'h5A; alu_in2 = 8'hFF; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_out("bp_hold");
      chk("bp_rdy_lo", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_hi", in_ready, 1);
    model(6, 'h5A, 'hFF);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check_out("bp_b");
    consume();

    // reset in the middle of an operation
    start_op(0, 'hFF, 'h01); wait_res("pre_rst"); consume();
    start_op(11, 'h0F, 'h11);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_out", alu_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_cflag = 0;
    #1;
    chk("mid_rst_rdy", in_ready, 1);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("mid_rst_novalid", seen, 0);
    start_op(1, 'h00, 'h00); wait_res("rst_cflag"); consume();

    // randomized ops with random hold time before consumption
    repeat (150) begin
      op = $urandom_range(0, 15);
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      start_op(op, a, b);
      wait_res("rnd");
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        check_out("rnd_hold");
      end
      consume();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 Parameter OPW, default 4, opcode width in bits; fixed at 4, held as a parameter for the package type.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 opcode  input  OPW  operation select, alu_op_t encoding.
REQ-008 alu_in1, alu_in2  input  WIDTH  operands; sampled only when in_valid && in_ready.
REQ-009 out_valid  output  1  result registers hold an unconsumed result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 alu_out  output  WIDTH  result (low half for MUL).
REQ-012 alu_out_hi  output  WIDTH  product high half for MUL; 0 for all other ops.
REQ-013 zero, carry, neg, ovf, err  output  1 each  flags registered with alu_out.

Function
REQ-014 Ops: ADD, ADDC, SUB, SUBC, AND, OR, XOR, NAND, SHL, SHR, ASR, MUL; remaining codes are illegal.
REQ-015 Internal carry register cflag; ADDC/SUBC use cflag as carry-in/borrow-in, never an external pin.
REQ-016 Arithmetic at WIDTH+1 bits; carry = bit WIDTH (borrow for SUB/SUBC); ovf = signed overflow; logic ops give carry=0, ovf=0.
REQ-017 Shifts by alu_in2[$clog2(WIDTH)-1:0]; carry = last bit shifted out (0 for shift amount 0); ovf=0.
REQ-018 zero = (alu_out==0), neg = alu_out[WIDTH-1]; for MUL zero tests full 2*WIDTH product.
REQ-019 cflag updates to the produced carry on completion of every legal op; illegal op leaves cflag unchanged.
REQ-020 Illegal opcode: alu_out=0, alu_out_hi=0, err=1, other flags 0, single-cycle latency.
REQ-021 FSM states IDLE, BUSY, HOLD.
REQ-022 IDLE: accept non-MUL -> result registered next edge, go HOLD (latency 1); accept MUL -> BUSY.
REQ-023 BUSY: unsigned shift-add multiply, one partial product per cycle, WIDTH cycles, then HOLD; in_ready=0 throughout.
REQ-024 HOLD: out_valid=1, outputs stable until out_valid && out_ready.
REQ-025 in_ready = (state==IDLE) || (state==HOLD && out_ready); a new op accepted in the consuming cycle gives back-to-back results with no bubble.
REQ-026 MUL: carry = (alu_out_hi != 0), ovf=0.
REQ-027 in_valid while in_ready=0 is ignored; no queuing.

Reset
REQ-028 On rst_n low, immediately: state=IDLE, out_valid=0, alu_out=0, alu_out_hi=0, all flags 0, cflag=0, multiply datapath cleared.
REQ-029 Reset during BUSY or HOLD discards the operation; no result emerges after release.
REQ-030 in_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-031 Macro SEQ_ALU_MUL_EN defined: MUL legal and BUSY state and multiplier present.
REQ-032 Macro SEQ_ALU_MUL_EN undefined: MUL code treated as illegal per REQ-020; no BUSY state or multiplier logic synthesised; alu_out_hi constant 0.

Structure
REQ-033 Package seq_alu_pkg holds alu_op_t enum, the state enum, and the OPW constant.
REQ-034 Iterative multiplier as sub-module seq_alu_mul with start/done, instantiated only under SEQ_ALU_MUL_EN.

Verification (WIDTH=8)
REQ-035 ADD 0xFF+0x01, then ADDC 0x00+0x00 -> first 0x00 zero=1 carry=1 one cycle after accept; second 0x01 carry=0.
REQ-036 SUB 0x05-0x07 -> 0xFE, carry=1, neg=1, ovf=0; ADD 0x7F+0x01 -> 0x80, ovf=1, neg=1.
REQ-037 MUL 0x0F*0x11 (macro on) -> alu_out=0xFF, alu_out_hi=0x00, carry=0, out_valid 9 cycles after accept, in_ready=0 while BUSY.
REQ-038 out_ready low 3 cycles after result -> outputs stable, in_ready=0; op offered concurrently is accepted in the cycle out_ready rises; its result follows next cycle.
REQ-039 rst_n pulsed mid-MUL -> out_valid stays 0, cflag=0, in_ready=1 after release.
REQ-040 Macro off, MUL or code 0xF -> err=1, alu_out=0, cflag unchanged from prior op.
